id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus EX operand preparation; sits directly upstream of the ALU.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/fwd_select.sv | 30 +++
 rtl/id_ex_operand_stage.sv | 192 +++++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings and ALU control codes for the MIPS-style integer pipeline.
// The ALU decodes the same 6-bit control values produced by the ID/EX stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b000010;

  // ALU control codes: R-type ops reuse funct, immediate logic ops reuse opcode.
  localparam logic [5:0] ALU_NOP  = 6'b000000;
  localparam logic [5:0] ALU_ADD  = FN_ADD;
  localparam logic [5:0] ALU_ADDI = OP_ADDI;
  localparam logic [5:0] ALU_ANDI = OP_ANDI;
  localparam logic [5:0] ALU_ORI  = OP_ORI;

  typedef struct packed {
    logic       valid;
    logic [5:0] func;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       use_imm;
  } ex_ctl_t;

  function automatic logic is_rtype_funct(input logic [5:0] funct);
    return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_MUL};
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding priority mux for one EX source operand: EX/MEM beats MEM/WB beats regfile.
// Register 0 is hardwired to zero and is never a forwarding target.
module fwd_select #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] reg_data,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic [DW-1:0] fwd_data
);

  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src);
  assign hit_memwb = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src);

  always_comb begin
    if (hit_exmem)      fwd_data = exmem_result;
    else if (hit_memwb) fwd_data = memwb_data;
    else                fwd_data = reg_data;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with ALU control decode, immediate extension, operand forwarding
// and load-use hazard detection feeding the IF/ID stall.
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [15:0]   id_imm,
  input  logic          flush,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic          stall,
  output logic          ex_valid,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [5:0]    alu_func,
  output logic [RW-1:0] ex_dest,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic [DW-1:0] ex_store_data
);

  // Decoded ID-stage values (next contents of the EX register)
  ex_ctl_t       dec_ctl;
  logic [RW-1:0] dec_dest;
  logic [RW-1:0] dec_rs;
  logic [RW-1:0] dec_rt;
  logic [DW-1:0] dec_rs_data;
  logic [DW-1:0] dec_rt_data;
  logic [DW-1:0] dec_imm;

  // Latched EX-stage state
  ex_ctl_t       ex_ctl;
  logic [RW-1:0] ex_dest_q;
  logic [RW-1:0] ex_rs;
  logic [RW-1:0] ex_rt;
  logic [DW-1:0] ex_rs_data;
  logic [DW-1:0] ex_rt_data;
  logic [DW-1:0] ex_imm;

  logic [DW-1:0] imm_sext;
  logic [DW-1:0] imm_zext;
  logic          id_uses_rt;
  logic          load_bubble;

  assign imm_sext = {{(DW-16){id_imm[15]}}, id_imm};
  assign imm_zext = {{(DW-16){1'b0}}, id_imm};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    dec_ctl     = '0;
    dec_dest    = '0;
    dec_rs      = '0;
    dec_rt      = '0;
    dec_rs_data = '0;
    dec_rt_data = '0;
    dec_imm     = '0;
    if (id_valid) begin
      unique case (id_opcode)
        OP_RTYPE: if (is_rtype_funct(id_funct)) begin
          dec_ctl.valid    = 1'b1;
          dec_ctl.func     = id_funct;
          dec_ctl.regwrite = 1'b1;
          dec_dest         = id_rd;
        end
        OP_ADDI, OP_ANDI, OP_ORI: begin
          dec_ctl.valid    = 1'b1;
          dec_ctl.func     = id_opcode;
          dec_ctl.regwrite = 1'b1;
          dec_ctl.use_imm  = 1'b1;
          dec_dest         = id_rt;
          dec_imm          = (id_opcode == OP_ADDI) ? imm_sext : imm_zext;
        end
        OP_LW: begin
          dec_ctl.valid    = 1'b1;
          dec_ctl.func     = ALU_ADD;
          dec_ctl.regwrite = 1'b1;
          dec_ctl.memread  = 1'b1;
          dec_ctl.use_imm  = 1'b1;
          dec_dest         = id_rt;
          dec_imm          = imm_sext;
        end
        OP_SW: begin
          dec_ctl.valid    = 1'b1;
          dec_ctl.func     = ALU_ADD;
          dec_ctl.memwrite = 1'b1;
          dec_ctl.use_imm  = 1'b1;
          dec_imm          = imm_sext;
        end
        default: ;
      endcase
      // Source fields only travel with a real instruction so bubbles never forward.
      if (dec_ctl.valid) begin
        dec_rs      = id_rs;
        dec_rt      = id_rt;
        dec_rs_data = id_rs_data;
        dec_rt_data = id_rt_data;
      end
    end
  end

  // Only R-type and SW read rt as a register; I-type and LW write it.
  assign id_uses_rt = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW);

  assign stall = id_valid && ex_ctl.valid && ex_ctl.memread && (ex_dest_q != '0) &&
                 ((ex_dest_q == id_rs) || ((ex_dest_q == id_rt) && id_uses_rt));

  assign load_bubble = flush || stall;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      ex_ctl     <= '0;
      ex_dest_q  <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
    end else if (load_bubble) begin
      ex_ctl     <= '0;
      ex_dest_q  <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
    end else begin
      ex_ctl     <= dec_ctl;
      ex_dest_q  <= dec_dest;
      ex_rs      <= dec_rs;
      ex_rt      <= dec_rt;
      ex_rs_data <= dec_rs_data;
      ex_rt_data <= dec_rt_data;
      ex_imm     <= dec_imm;
    end
  end

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  fwd_select #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src            (ex_rs),
    .reg_data       (ex_rs_data),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_data     (memwb_data),
    .fwd_data       (fwd_rs)
  );

  fwd_select #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src            (ex_rt),
    .reg_data       (ex_rt_data),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_data     (memwb_data),
    .fwd_data       (fwd_rt)
  );

  assign alu_a         = fwd_rs;
  assign alu_b         = ex_ctl.use_imm ? ex_imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_func      = ex_ctl.func;
  assign ex_valid      = ex_ctl.valid;
  assign ex_dest       = ex_dest_q;
  assign ex_regwrite   = ex_ctl.regwrite;
  assign ex_memread    = ex_ctl.memread;
  assign ex_memwrite   = ex_ctl.memwrite;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: decode, immediates, forwarding priority,
// load-use stall, flush and asynchronous reset, with hand-computed expectations.
module tb_id_ex_operand_stage;
  import mips_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [5:0]    id_opcode;
  logic [5:0]    id_funct;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rs_data, id_rt_data;
  logic [15:0]   id_imm;
  logic          flush;
  logic          exmem_regwrite;
  logic [RW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_regwrite;
  logic [RW-1:0] memwb_rd;
  logic [DW-1:0] memwb_data;
  logic          stall;
  logic          ex_valid;
  logic [DW-1:0] alu_a, alu_b;
  logic [5:0]    alu_func;
  logic [RW-1:0] ex_dest;
  logic          ex_regwrite, ex_memread, ex_memwrite;
  logic [DW-1:0] ex_store_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DW(DW), .RW(RW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_funct       (id_funct),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm         (id_imm),
    .flush          (flush),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_data     (memwb_data),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_func       (alu_func),
    .ex_dest        (ex_dest),
    .ex_regwrite    (ex_regwrite),
    .ex_memread     (ex_memread),
    .ex_memwrite    (ex_memwrite),
    .ex_store_data  (ex_store_data)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                        input logic [DW-1:0] rsd, input logic [DW-1:0] rtd, input logic [15:0] imm);
    id_valid   = v;
    id_opcode  = op;
    id_funct   = fn;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_rs_data = rsd;
    id_rt_data = rtd;
    id_imm     = imm;
  endtask

  task automatic clear_fwd();
    exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_data = '0;
  endtask

  // Rising edge, then settle 1 time unit before touching inputs or sampling outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    clear_fwd();
    set_id(1'b0, 6'd0, 6'd0, '0, '0, '0, '0, '0, '0);
    #12;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_alu_func", 32'(alu_func), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_regwrite", 32'(ex_regwrite), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADDI r2 = r1 + (-1)
    set_id(1'b1, OP_ADDI, 6'd0, 5'd1, 5'd2, 5'd9, 32'd5, 32'h77, 16'hFFFF);
    tick();
    check("addi_valid", 32'(ex_valid), 32'd1);
    check("addi_a", alu_a, 32'd5);
    check("addi_b", alu_b, 32'hFFFF_FFFF);
    check("addi_func", 32'(alu_func), 32'(6'b001000));
    check("addi_dest", 32'(ex_dest), 32'd2);
    check("addi_regwrite", 32'(ex_regwrite), 32'd1);

    // ORI / ANDI zero-extend
    set_id(1'b1, OP_ORI, 6'd0, 5'd3, 5'd4, 5'd0, 32'h10, 32'h0, 16'h8001);
    tick();
    check("ori_a", alu_a, 32'h10);
    check("ori_b", alu_b, 32'h0000_8001);
    check("ori_func", 32'(alu_func), 32'(6'b001101));
    set_id(1'b1, OP_ANDI, 6'd0, 5'd3, 5'd6, 5'd0, 32'h10, 32'h0, 16'hF0F0);
    tick();
    check("andi_b", alu_b, 32'h0000_F0F0);
    check("andi_func", 32'(alu_func), 32'(6'b001100));
    check("andi_dest", 32'(ex_dest), 32'd6);

    // ADD r3 = r1 + r2 with forwarding priority
    set_id(1'b1, OP_RTYPE, FN_ADD, 5'd1, 5'd2, 5'd3, 32'd100, 32'd200, 16'h0);
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd1; exmem_result = 32'd7;
    memwb_regwrite = 1'b1; memwb_rd = 5'd1; memwb_data = 32'd9;
    #1;
    check("add_fwd_exmem_a", alu_a, 32'd7);
    check("add_b_regfile", alu_b, 32'd200);
    check("add_func", 32'(alu_func), 32'(6'b100000));
    check("add_dest", 32'(ex_dest), 32'd3);
    exmem_regwrite = 1'b0;
    #1;
    check("add_fwd_memwb_a", alu_a, 32'd9);
    memwb_rd = 5'd2;
    #1;
    check("add_a_regfile", alu_a, 32'd100);
    check("add_fwd_memwb_b", alu_b, 32'd9);
    clear_fwd();

    // MUL, then r0 sources must never pick up forwarded data
    set_id(1'b1, OP_RTYPE, FN_MUL, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 16'h0);
    tick();
    check("mul_func", 32'(alu_func), 32'(6'b000010));
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'd55;
    memwb_regwrite = 1'b1; memwb_rd = 5'd0; memwb_data = 32'd66;
    #1;
    check("r0_no_fwd_a", alu_a, 32'd0);
    check("r0_no_fwd_b", alu_b, 32'd0);
    clear_fwd();

    // Load-use: LW r4, then SUB r5 = r4 - r2
    set_id(1'b1, OP_LW, 6'd0, 5'd1, 5'd4, 5'd0, 32'h100, 32'h0, 16'h0004);
    tick();
    check("lw_memread", 32'(ex_memread), 32'd1);
    check("lw_func", 32'(alu_func), 32'(6'b100000));
    check("lw_addr_a", alu_a, 32'h100);
    check("lw_addr_b", alu_b, 32'd4);
    check("lw_dest", 32'(ex_dest), 32'd4);
    set_id(1'b1, OP_RTYPE, FN_SUB, 5'd4, 5'd2, 5'd5, 32'hDEAD, 32'd3, 16'h0);
    #1;
    check("loaduse_stall", 32'(stall), 32'd1);
    tick();
    check("bubble_valid", 32'(ex_valid), 32'd0);
    check("bubble_regwrite", 32'(ex_regwrite), 32'd0);
    check("bubble_no_stall", 32'(stall), 32'd0);
    memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_data = 32'h42;
    tick();
    check("sub_fwd_memwb_a", alu_a, 32'h42);
    check("sub_b", alu_b, 32'd3);
    check("sub_func", 32'(alu_func), 32'(6'b100010));
    check("sub_dest", 32'(ex_dest), 32'd5);
    clear_fwd();

    // Stall only when rt is actually read
    set_id(1'b1, OP_LW, 6'd0, 5'd1, 5'd4, 5'd0, 32'h100, 32'h0, 16'h0);
    tick();
    set_id(1'b1, OP_ADDI, 6'd0, 5'd1, 5'd4, 5'd0, 32'd1, 32'd0, 16'h0001);
    #1;
    check("addi_rt_no_stall", 32'(stall), 32'd0);
    set_id(1'b1, OP_SW, 6'd0, 5'd1, 5'd4, 5'd0, 32'd1, 32'd0, 16'h0001);
    #1;
    check("sw_rt_stall", 32'(stall), 32'd1);
    id_valid = 1'b0;
    #1;
    check("invalid_id_no_stall", 32'(stall), 32'd0);
    id_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_stall_asserted", 32'(stall), 32'd1);
    tick();
    flush = 1'b0;
    check("flush_stall_valid", 32'(ex_valid), 32'd0);
    check("flush_stall_memwrite", 32'(ex_memwrite), 32'd0);

    // LW to r0 never stalls
    set_id(1'b1, OP_LW, 6'd0, 5'd1, 5'd0, 5'd0, 32'h100, 32'h0, 16'h0);
    tick();
    set_id(1'b1, OP_RTYPE, FN_ADD, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 16'h0);
    #1;
    check("lw_r0_no_stall", 32'(stall), 32'd0);

    // Flush a valid ADD
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_regwrite", 32'(ex_regwrite), 32'd0);

    // SW: negative offset, store data forwarded, immediate keeps alu_b
    set_id(1'b1, OP_SW, 6'd0, 5'd1, 5'd6, 5'd0, 32'h200, 32'hAA, 16'hFFFC);
    tick();
    check("sw_memwrite", 32'(ex_memwrite), 32'd1);
    check("sw_regwrite", 32'(ex_regwrite), 32'd0);
    check("sw_b", alu_b, 32'hFFFF_FFFC);
    check("sw_store", ex_store_data, 32'hAA);
    exmem_regwrite = 1'b1; exmem_rd = 5'd6; exmem_result = 32'hBB;
    #1;
    check("sw_store_fwd", ex_store_data, 32'hBB);
    check("sw_b_imm_wins", alu_b, 32'hFFFF_FFFC);
    clear_fwd();

    // Unsupported encodings and id_valid=0 give bubbles
    set_id(1'b1, OP_RTYPE, 6'b000011, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'h0);
    tick();
    check("bad_funct_valid", 32'(ex_valid), 32'd0);
    check("bad_funct_func", 32'(alu_func), 32'd0);
    set_id(1'b1, 6'b000100, 6'd0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'h0);
    tick();
    check("bad_op_valid", 32'(ex_valid), 32'd0);
    set_id(1'b0, OP_ADDI, 6'd0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'h1);
    tick();
    check("idle_valid", 32'(ex_valid), 32'd0);
    check("idle_regwrite", 32'(ex_regwrite), 32'd0);

    // Asynchronous reset discards an in-flight instruction without a clock edge
    set_id(1'b1, OP_RTYPE, FN_OR, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'h0);
    tick();
    check("pre_reset_valid", 32'(ex_valid), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(ex_valid), 32'd0);
    check("async_rst_func", 32'(alu_func), 32'd0);
    check("async_rst_regwrite", 32'(ex_regwrite), 32'd0);
    check("async_rst_a", alu_a, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
